// File: rtl/multi_alarm_timekeeper_pkg.sv
// Shared definitions for the alarm clock timekeeper: FSM state encodings and field limits.
package multi_alarm_timekeeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_e;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

  function automatic logic [4:0] hmax(input int mode_24h);
    return (mode_24h != 0) ? 5'd23 : 5'd11;
  endfunction

endpackage

// File: rtl/multi_alarm_timekeeper_tick_prescaler.sv
// 1 Hz prescaler: one-cycle sec_pulse on the terminal count, plus a first-half-second phase flag.
module tick_prescaler #(
  parameter int CLK_HZ = 31500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic sec_pulse,
  output logic half_on
);

  localparam int            PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TC   = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (clear || (cnt_q == TC)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign sec_pulse = (cnt_q == TC);
  assign half_on   = (cnt_q < HALF);

endmodule

// File: rtl/multi_alarm_timekeeper.sv
// Timekeeping core: h/m/s counters, NUM_ALARMS alarms, ringing FSM and gated buzzer tone.
// Optional snooze state is built only when ALARM_SNOOZE_EN is defined.
//
// state   | meaning
// IDLE    | no alarm active, watching for a match at each minute rollover
// RINGING | alarm ring_idx sounding, ring timer counting ticks down
// SNOOZE  | ring suspended, snooze timer counting ticks down to re-ring
module multi_alarm_timekeeper
  import multi_alarm_timekeeper_pkg::*;
#(
  parameter int CLK_HZ     = 31500000,
  parameter int NUM_ALARMS = 2,
  parameter int MODE_24H   = 0,
  parameter int BUZZ_HZ    = 3150,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sec_adj,
  input  logic                      min_adj,
  input  logic                      hr_adj,
  input  logic                      al_sel,
  input  logic                      al_min_adj,
  input  logic                      al_hr_adj,
  input  logic                      al_toggle,
  input  logic                      dismiss,
  input  logic                      snooze,
  output logic [5:0]                seconds,
  output logic [5:0]                minutes,
  output logic [4:0]                hours,
  output logic [NUM_ALARMS*6-1:0]   al_minutes_flat,
  output logic [NUM_ALARMS*5-1:0]   al_hours_flat,
  output logic [NUM_ALARMS-1:0]     al_on,
  output logic [2:0]                al_sel_idx,
  output logic [2:0]                ring_idx,
  output logic                      ringing,
  output logic                      sec_pulse,
  output logic                      buzzer_out
);

  localparam logic [4:0]    HMAX        = hmax(MODE_24H);
  localparam logic [2:0]    SEL_LAST    = 3'(NUM_ALARMS - 1);
  localparam int            BUZZ_HALF_I = (CLK_HZ / (2 * BUZZ_HZ) > 0) ? CLK_HZ / (2 * BUZZ_HZ) : 1;
  localparam int            BW          = $clog2(BUZZ_HALF_I + 1);
  localparam logic [BW-1:0] BUZZ_RELOAD = BW'(BUZZ_HALF_I - 1);
  localparam int            RW          = $clog2(RING_SEC + 1);
  localparam logic [RW-1:0] RING_LOAD   = RW'(RING_SEC);
`ifdef ALARM_SNOOZE_EN
  localparam int            SW          = $clog2(SNOOZE_MIN * 60 + 1);
  localparam logic [SW-1:0] SNZ_LOAD    = SW'(SNOOZE_MIN * 60);
`endif

  logic tick_raw, half_on;

  tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (sec_adj),
    .sec_pulse (tick_raw),
    .half_on   (half_on)
  );

  logic [5:0] sec_q, sec_d, min_q, min_d;
  logic [4:0] hr_q, hr_d;
  logic       pend_q, pend_d;
  logic       any_adj, tick_req, tick, min_roll;

  logic [NUM_ALARMS-1:0][5:0] al_m_q, al_m_d;
  logic [NUM_ALARMS-1:0][4:0] al_h_q, al_h_d;
  logic [NUM_ALARMS-1:0]      al_on_q, al_on_d;
  logic [2:0]                 sel_q, sel_d;

  state_e        state_q, state_d;
  logic [2:0]    ring_idx_q, ring_idx_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [BW-1:0] buz_cnt_q, buz_cnt_d;
  logic          tone_q, tone_d;
  logic          hit_any, ring_on, toggle_clear;
  logic [2:0]    hit_idx;
`ifdef ALARM_SNOOZE_EN
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
`else
  logic          unused_snooze;
  assign unused_snooze = snooze;
`endif

  // A tick colliding with a manual adjust is deferred one cycle; sec_adj drops it entirely.
  assign any_adj  = sec_adj | min_adj | hr_adj;
  assign tick_req = tick_raw | pend_q;
  assign tick     = tick_req & ~any_adj;
  assign pend_d   = tick_req & any_adj & ~sec_adj;
  assign min_roll = tick && (sec_q == SEC_MAX);

  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (tick) begin
      if (sec_q == SEC_MAX) begin
        sec_d = '0;
        if (min_q == MIN_MAX) begin
          min_d = '0;
          hr_d  = (hr_q == HMAX) ? 5'd0 : hr_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else begin
      if (sec_adj) sec_d = '0;
      if (min_adj) min_d = (min_q == MIN_MAX) ? 6'd0 : min_q + 6'd1;
      if (hr_adj)  hr_d  = (hr_q == HMAX) ? 5'd0 : hr_q + 5'd1;
    end
  end

  always_comb begin
    al_m_d  = al_m_q;
    al_h_d  = al_h_q;
    al_on_d = al_on_q;
    sel_d   = sel_q;
    if (al_sel) sel_d = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (sel_q == 3'(i)) begin
        if (al_min_adj) al_m_d[i] = (al_m_q[i] == MIN_MAX) ? 6'd0 : al_m_q[i] + 6'd1;
        if (al_hr_adj)  al_h_d[i] = (al_h_q[i] == HMAX) ? 5'd0 : al_h_q[i] + 5'd1;
        if (al_toggle)  al_on_d[i] = ~al_on_q[i];
      end
    end
  end

  // Descending scan so the lowest matching alarm index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = 3'd0;
    ring_on = 1'b0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (al_on_q[i] && (al_h_q[i] == hr_d) && (al_m_q[i] == min_d)) begin
        hit_any = 1'b1;
        hit_idx = 3'(i);
      end
      if (ring_idx_q == 3'(i)) ring_on = al_on_q[i];
    end
  end

  assign toggle_clear = al_toggle && (sel_q == ring_idx_q) && ring_on;

  always_comb begin
    state_d    = state_q;
    ring_idx_d = ring_idx_q;
    ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d  = snz_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (min_roll && hit_any) begin
          state_d    = ST_RINGING;
          ring_idx_d = hit_idx;
          ring_cnt_d = RING_LOAD;
        end
      end
      ST_RINGING: begin
        if (dismiss || toggle_clear) state_d = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
        else if (snooze) begin
          state_d   = ST_SNOOZE;
          snz_cnt_d = SNZ_LOAD;
        end
`endif
        else if (tick) begin
          if (ring_cnt_q <= RW'(1)) state_d = ST_IDLE;
          else                      ring_cnt_d = ring_cnt_q - RW'(1);
        end
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (dismiss || toggle_clear) state_d = ST_IDLE;
        else if (tick) begin
          if (snz_cnt_q <= SW'(1)) begin
            state_d    = ST_RINGING;
            ring_cnt_d = RING_LOAD;
          end else begin
            snz_cnt_d = snz_cnt_q - SW'(1);
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    buz_cnt_d = '0;
    tone_d    = 1'b0;
    if (state_q == ST_RINGING) begin
      if (buz_cnt_q == '0) begin
        buz_cnt_d = BUZZ_RELOAD;
        tone_d    = ~tone_q;
      end else begin
        buz_cnt_d = buz_cnt_q - BW'(1);
        tone_d    = tone_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ring_idx_q <= '0;
      ring_cnt_q <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ring_idx_q <= ring_idx_d;
      ring_cnt_q <= ring_cnt_d;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q  <= snz_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
      pend_q    <= 1'b0;
      al_m_q    <= '0;
      al_h_q    <= '0;
      al_on_q   <= '0;
      sel_q     <= '0;
      buz_cnt_q <= '0;
      tone_q    <= 1'b0;
    end else begin
      sec_q     <= sec_d;
      min_q     <= min_d;
      hr_q      <= hr_d;
      pend_q    <= pend_d;
      al_m_q    <= al_m_d;
      al_h_q    <= al_h_d;
      al_on_q   <= al_on_d;
      sel_q     <= sel_d;
      buz_cnt_q <= buz_cnt_d;
      tone_q    <= tone_d;
    end
  end

  always_comb begin
    ringing    = (state_q == ST_RINGING);
    buzzer_out = ringing && tone_q && half_on;
  end

  assign seconds         = sec_q;
  assign minutes         = min_q;
  assign hours           = hr_q;
  assign al_minutes_flat = al_m_q;
  assign al_hours_flat   = al_h_q;
  assign al_on           = al_on_q;
  assign al_sel_idx      = sel_q;
  assign ring_idx        = ring_idx_q;
  assign sec_pulse       = tick_raw;

endmodule

// File: tb/tb_multi_alarm_timekeeper.sv
// Scoreboard bench for multi_alarm_timekeeper: a 12h and a 24h instance share all inputs.
module tb_multi_alarm_timekeeper;

  localparam int CLK_HZ = 10, NA = 2, BUZZ_HZ = 2, RING_SEC = 3, SNOOZE_MIN = 1;
  localparam int P_SEC = 0, P_MIN = 1, P_HR = 2, P_SEL = 3, P_AMIN = 4, P_AHR = 5,
                 P_TOG = 6, P_DIS = 7, P_SNZ = 8;

  logic clk = 1'b0, reset_n = 1'b0;
  logic sec_adj = 0, min_adj = 0, hr_adj = 0, al_sel = 0, al_min_adj = 0, al_hr_adj = 0;
  logic al_toggle = 0, dismiss = 0, snooze = 0;

  logic [5:0] seconds, minutes, t24_seconds, t24_minutes;
  logic [4:0] hours, t24_hours;
  logic [NA*6-1:0] al_minutes_flat, t24_al_minutes_flat;
  logic [NA*5-1:0] al_hours_flat, t24_al_hours_flat;
  logic [NA-1:0] al_on, t24_al_on;
  logic [2:0] al_sel_idx, ring_idx, t24_al_sel_idx, t24_ring_idx;
  logic ringing, sec_pulse, buzzer_out, t24_ringing, t24_sec_pulse, t24_buzzer_out;

  multi_alarm_timekeeper #(.CLK_HZ(CLK_HZ), .NUM_ALARMS(NA), .MODE_24H(0), .BUZZ_HZ(BUZZ_HZ),
    .RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN)) dut (
    .clk(clk), .reset_n(reset_n), .sec_adj(sec_adj), .min_adj(min_adj), .hr_adj(hr_adj),
    .al_sel(al_sel), .al_min_adj(al_min_adj), .al_hr_adj(al_hr_adj), .al_toggle(al_toggle),
    .dismiss(dismiss), .snooze(snooze), .seconds(seconds), .minutes(minutes), .hours(hours),
    .al_minutes_flat(al_minutes_flat), .al_hours_flat(al_hours_flat), .al_on(al_on),
    .al_sel_idx(al_sel_idx), .ring_idx(ring_idx), .ringing(ringing), .sec_pulse(sec_pulse),
    .buzzer_out(buzzer_out));

  multi_alarm_timekeeper #(.CLK_HZ(CLK_HZ), .NUM_ALARMS(NA), .MODE_24H(1), .BUZZ_HZ(BUZZ_HZ),
    .RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN)) dut24 (
    .clk(clk), .reset_n(reset_n), .sec_adj(sec_adj), .min_adj(min_adj), .hr_adj(hr_adj),
    .al_sel(al_sel), .al_min_adj(al_min_adj), .al_hr_adj(al_hr_adj), .al_toggle(al_toggle),
    .dismiss(dismiss), .snooze(snooze), .seconds(t24_seconds), .minutes(t24_minutes),
    .hours(t24_hours), .al_minutes_flat(t24_al_minutes_flat), .al_hours_flat(t24_al_hours_flat),
    .al_on(t24_al_on), .al_sel_idx(t24_al_sel_idx), .ring_idx(t24_ring_idx),
    .ringing(t24_ringing), .sec_pulse(t24_sec_pulse), .buzzer_out(t24_buzzer_out));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  string exp_name[$];
  logic [31:0] exp_val[$];
  logic [31:0] obs[$];

  task automatic expect_val(input string n, input logic [31:0] v);
    exp_name.push_back(n);
    exp_val.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input int id, input int times);
    for (int i = 0; i < times; i++) begin
      case (id)
        P_SEC: sec_adj = 1;    P_MIN: min_adj = 1;    P_HR: hr_adj = 1;
        P_SEL: al_sel = 1;     P_AMIN: al_min_adj = 1; P_AHR: al_hr_adj = 1;
        P_TOG: al_toggle = 1;  P_DIS: dismiss = 1;    P_SNZ: snooze = 1;
        default: ;
      endcase
      step(1);
      {sec_adj, min_adj, hr_adj, al_sel, al_min_adj, al_hr_adj, al_toggle, dismiss, snooze} = '0;
      step(1);
    end
  endtask

  task automatic do_reset();
    step(1);
    #2 reset_n = 0;
    #2 reset_n = 1;
  endtask

  // Leaves the bench just after the edge at which seconds reaches s with the prescaler at 0.
  task automatic set_clock(input int h, input int m, input int s);
    pulse(P_HR, h);
    pulse(P_MIN, m);
    pulse(P_SEC, 1);
    step(10 * s - 1);
  endtask

  task automatic compare_all();
    string n;
    logic [31:0] v;
    foreach (obs[k]) begin
      n = exp_name.pop_front();
      v = exp_val.pop_front();
      vectors++;
      if (obs[k] !== v) begin
        miscompares++;
        $display("FAIL %s: observed %0d, expected %0d", n, obs[k], v);
      end
    end
    obs.delete();
  endtask

  task automatic test_reset();
    int n;
    step(2);
    #2 reset_n = 1;
    step(37);
    #2 reset_n = 0;
    #1;
    expect_val("rst_seconds", 0); expect_val("rst_minutes", 0); expect_val("rst_hours", 0);
    expect_val("rst_al_min", 0);  expect_val("rst_al_hr", 0);   expect_val("rst_al_on", 0);
    expect_val("rst_sel", 0);     expect_val("rst_ring_idx", 0); expect_val("rst_ringing", 0);
    expect_val("rst_sec_pulse", 0); expect_val("rst_buzzer", 0);
    obs.push_back(32'(seconds)); obs.push_back(32'(minutes)); obs.push_back(32'(hours));
    obs.push_back(32'(al_minutes_flat)); obs.push_back(32'(al_hours_flat));
    obs.push_back(32'(al_on)); obs.push_back(32'(al_sel_idx)); obs.push_back(32'(ring_idx));
    obs.push_back(32'(ringing)); obs.push_back(32'(sec_pulse)); obs.push_back(32'(buzzer_out));
    compare_all();
    #2 reset_n = 1;
    // Release falls inside cycle 1 (prescaler 0); the pulse belongs to cycle 10, nine edges on.
    expect_val("first_pulse_edges", 9);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (sec_pulse === 1'b1) begin n = i; break; end
    end
    obs.push_back(32'(n));
    step(1);
    expect_val("first_second", 1);
    obs.push_back(32'(seconds));
    compare_all();
  endtask

  task automatic test_rollover_12h();
    do_reset();
    set_clock(11, 59, 59);
    expect_val("pre12_h", 11); expect_val("pre12_m", 59); expect_val("pre12_s", 59);
    obs.push_back(32'(hours)); obs.push_back(32'(minutes)); obs.push_back(32'(seconds));
    step(10);
    expect_val("roll12_h", 0); expect_val("roll12_m", 0); expect_val("roll12_s", 0);
    expect_val("roll24_11_h", 12); expect_val("roll24_11_m", 0); expect_val("roll24_11_s", 0);
    obs.push_back(32'(hours)); obs.push_back(32'(minutes)); obs.push_back(32'(seconds));
    obs.push_back(32'(t24_hours)); obs.push_back(32'(t24_minutes)); obs.push_back(32'(t24_seconds));
    compare_all();
  endtask

  task automatic test_rollover_24h();
    do_reset();
    set_clock(23, 59, 59);
    expect_val("pre24_h", 23); expect_val("pre12_wrap_h", 11);
    obs.push_back(32'(t24_hours)); obs.push_back(32'(hours));
    step(10);
    expect_val("roll24_h", 0); expect_val("roll24_m", 0); expect_val("roll24_s", 0);
    obs.push_back(32'(t24_hours)); obs.push_back(32'(t24_minutes)); obs.push_back(32'(t24_seconds));
    compare_all();
  endtask

  task automatic test_adjust_tick();
    do_reset();
    pulse(P_MIN, 59);
    pulse(P_SEC, 1);
    step(8);
    expect_val("adj_pulse_high", 1); expect_val("adj_pre_min", 59);
    obs.push_back(32'(sec_pulse)); obs.push_back(32'(minutes));
    min_adj = 1;
    step(1);
    min_adj = 0;
    expect_val("adj_min_wrap", 0); expect_val("adj_hr_hold", 0); expect_val("adj_sec_held", 0);
    obs.push_back(32'(minutes)); obs.push_back(32'(hours)); obs.push_back(32'(seconds));
    step(1);
    expect_val("adj_sec_late", 1); expect_val("adj_min_after", 0);
    obs.push_back(32'(seconds)); obs.push_back(32'(minutes));
    compare_all();
  endtask

  task automatic test_alarm_ring();
    do_reset();
    pulse(P_AHR, 1); pulse(P_TOG, 1); pulse(P_SEL, 1); pulse(P_AHR, 1); pulse(P_TOG, 1);
    expect_val("al_on_both", 3); expect_val("al_hours_both", (1 << 5) | 1); expect_val("al_sel_one", 1);
    obs.push_back(32'(al_on)); obs.push_back(32'(al_hours_flat)); obs.push_back(32'(al_sel_idx));
    set_clock(0, 59, 59);
    expect_val("ring_pre", 0);
    obs.push_back(32'(ringing));
    step(10);
    expect_val("ring_start", 1); expect_val("ring_idx_low", 0); expect_val("ring_hours", 1);
    expect_val("buzz_first", 0);
    obs.push_back(32'(ringing)); obs.push_back(32'(ring_idx)); obs.push_back(32'(hours));
    obs.push_back(32'(buzzer_out));
    step(1);
    expect_val("buzz_on", 1);
    obs.push_back(32'(buzzer_out));
    step(4);
    expect_val("buzz_gated", 0); expect_val("ring_mid", 1);
    obs.push_back(32'(buzzer_out)); obs.push_back(32'(ringing));
    step(24);
    expect_val("ring_before_timeout", 1);
    obs.push_back(32'(ringing));
    step(1);
    expect_val("ring_timeout", 0); expect_val("buzz_timeout", 0);
    obs.push_back(32'(ringing)); obs.push_back(32'(buzzer_out));
    pulse(P_SEL, 1);
    expect_val("sel_wrap", 0);
    obs.push_back(32'(al_sel_idx));
    compare_all();
  endtask

  task automatic test_toggle_stop();
    do_reset();
    pulse(P_AHR, 1); pulse(P_TOG, 1);
    set_clock(0, 59, 59);
    step(10);
    expect_val("tog_ring", 1);
    obs.push_back(32'(ringing));
    step(1);
    expect_val("tog_buzz_on", 1);
    obs.push_back(32'(buzzer_out));
    al_toggle = 1;
    step(1);
    al_toggle = 0;
    expect_val("tog_ringing", 0); expect_val("tog_buzz", 0); expect_val("tog_al_on", 0);
    obs.push_back(32'(ringing)); obs.push_back(32'(buzzer_out)); obs.push_back(32'(al_on));
    compare_all();
  endtask

  task automatic test_dismiss();
    do_reset();
    pulse(P_SEL, 1); pulse(P_AHR, 1); pulse(P_TOG, 1);
    set_clock(0, 59, 59);
    step(10);
    expect_val("dis_ring", 1); expect_val("dis_ring_idx", 1);
    obs.push_back(32'(ringing)); obs.push_back(32'(ring_idx));
    pulse(P_DIS, 1);
    expect_val("dis_stop", 0); expect_val("dis_al_on_kept", 2);
    obs.push_back(32'(ringing)); obs.push_back(32'(al_on));
    compare_all();
  endtask

  task automatic test_snooze();
    do_reset();
    pulse(P_AHR, 1); pulse(P_TOG, 1);
    set_clock(0, 59, 59);
    step(10);
    expect_val("snz_ring", 1);
    obs.push_back(32'(ringing));
    snooze = 1;
    step(1);
    snooze = 0;
    expect_val("snz_quiet", 0);
    obs.push_back(32'(ringing));
    step(598);
    expect_val("snz_still_quiet", 0);
    obs.push_back(32'(ringing));
    step(1);
    expect_val("snz_rering", 1);
    obs.push_back(32'(ringing));
    dismiss = 1;
    step(1);
    dismiss = 0;
    expect_val("snz_dismiss", 0);
    obs.push_back(32'(ringing));
    compare_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rollover_12h();
    test_rollover_24h();
    test_adjust_tick();
    test_alarm_ring();
    test_toggle_stop();
    test_dismiss();
`ifdef ALARM_SNOOZE_EN
    test_snooze();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
